// File: rtl/multdiv_sequencer_pkg.sv
// multdiv_sequencer_pkg: shared decode constants, exception codes and state encoding
package multdiv_sequencer_pkg;
    localparam logic [4:0] R_TYPE  = 5'b00000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam int TIMEOUT_DEF = 40;
    localparam int RSTATUS_IDX = 30;
    localparam int MUL_EXC     = 4;
    localparam int DIV_EXC     = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/multdiv_sequencer_md_timeout_counter.sv
// md_timeout_counter: clearable enabled up-counter flagging terminal count MAX-1
module md_timeout_counter #(
    parameter int MAX = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] count;
    always_ff @(posedge clock) begin
        count <= (reset || clr) ? '0 : en ? count + 1'b1 : count;
    end
    assign tc = count == W'(MAX - 1);
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mul/div to the shared multdiv unit and stalls X until result or timeout
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int RSTATUS_REG  = RSTATUS_IDX,
    parameter int MUL_EXC_CODE = MUL_EXC,
    parameter int DIV_EXC_CODE = DIV_EXC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_X,
    input  logic [31:0] A_X,
    input  logic [31:0] B_X,
    input  logic        kill,
    input  logic [31:0] md_result,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [4:0]  result_reg,
    output logic        result_exc
);
    state_t state, state_n;
    logic [4:0]  rd_q;
    logic        div_q, exc_q;
    logic [31:0] op_a_q, op_b_q, res_q;
    logic        is_rtype, is_mul, is_div, issue, busy, done, finish, tc;
    logic        unused;
    assign unused = ^{IR_X[21:7], IR_X[1:0]};
    md_timeout_counter #(.MAX(TIMEOUT)) u_timeout (
        .clock(clock),
        .reset(reset),
        .clr  (issue),
        .en   (busy),
        .tc   (tc)
    );
    always_comb begin
        is_rtype     = IR_X[31:27] == R_TYPE;
        is_mul       = is_rtype && IR_X[6:2] == ALU_MUL;
        is_div       = is_rtype && IR_X[6:2] == ALU_DIV;
        issue        = state == IDLE && (is_mul || is_div) && !kill;
        busy         = state == BUSY;
        done         = state == DONE && !kill;
        finish       = busy && !kill && (md_ready || tc);
        state_n      = state == IDLE ? (issue ? BUSY : IDLE)
                     : state == BUSY ? (kill ? IDLE : finish ? DONE : BUSY)
                     : IDLE;
        ctrl_MULT    = issue && is_mul;
        ctrl_DIV     = issue && is_div;
        md_opA       = issue ? A_X : op_a_q;
        md_opB       = issue ? B_X : op_b_q;
        stall        = issue || (busy && !kill);
        result_valid = done;
        result_exc   = done && exc_q;
        result_reg   = !done ? 5'd0 : exc_q ? 5'(RSTATUS_REG) : rd_q;
        result_data  = !done ? 32'd0
                     : exc_q ? (div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE))
                     : res_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rd_q   <= '0;
            div_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            res_q  <= '0;
            exc_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (issue) begin
                rd_q   <= IR_X[26:22];
                div_q  <= is_div;
                op_a_q <= A_X;
                op_b_q <= B_X;
            end
            if (finish) begin
                res_q <= md_ready ? md_result : '0;
                exc_q <= md_ready ? md_exception : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed scenarios against a cycle-indexed expectation model
module tb_multdiv_sequencer;
    localparam int TO = 40;
    logic        clock = 1'b0;
    logic        reset, kill, md_ready, md_exception;
    logic [31:0] IR_X, A_X, B_X, md_result;
    logic        ctrl_MULT, ctrl_DIV, stall, result_valid, result_exc;
    logic [31:0] md_opA, md_opB, result_data;
    logic [4:0]  result_reg;
    logic        chk_en, opchk, e_mult, e_div, e_stall, e_valid, e_exc;
    logic [31:0] e_opa, e_opb, e_data;
    logic [4:0]  e_reg;
    int passed = 0, total = 0;
    int n_stall, n_valid, n_mult, n_div;
    logic [31:0] last_data;
    logic [4:0]  last_reg;
    logic        last_exc;
    always #5 clock = ~clock;
    multdiv_sequencer #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .IR_X(IR_X), .A_X(A_X), .B_X(B_X), .kill(kill),
        .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
        .stall(stall), .result_valid(result_valid), .result_data(result_data),
        .result_reg(result_reg), .result_exc(result_exc)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act === ex) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    endtask
    always @(negedge clock) begin
        if (chk_en) begin
            chk("ctrl_MULT", 32'(ctrl_MULT), 32'(e_mult));
            chk("ctrl_DIV", 32'(ctrl_DIV), 32'(e_div));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("result_valid", 32'(result_valid), 32'(e_valid));
            chk("result_exc", 32'(result_exc), 32'(e_exc));
            chk("result_reg", 32'(result_reg), 32'(e_reg));
            chk("result_data", result_data, e_data);
            if (opchk) begin
                chk("md_opA", md_opA, e_opa);
                chk("md_opB", md_opB, e_opb);
            end
            n_stall += int'(stall);
            n_valid += int'(result_valid);
            n_mult  += int'(ctrl_MULT);
            n_div   += int'(ctrl_DIV);
            if (result_valid) begin
                last_data = result_data;
                last_reg  = result_reg;
                last_exc  = result_exc;
            end
        end
    end
    function automatic logic [31:0] rtype(input logic [4:0] alu, rd, rs, rt);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic clr_counts();
        n_stall = 0; n_valid = 0; n_mult = 0; n_div = 0;
        last_data = '1; last_reg = '1; last_exc = 1'bx;
    endtask
    task automatic set_quiet();
        e_mult = 0; e_div = 0; e_stall = 0; e_valid = 0; e_exc = 0; e_reg = 0; e_data = 0;
    endtask
    task automatic idle(input int n, input logic [31:0] ir, input logic k);
        for (int i = 0; i < n; i++) begin
            step();
            reset = 0; IR_X = ir; A_X = 32'h11; B_X = 32'h22; kill = k;
            md_ready = 0; md_result = 32'hdead_beef; md_exception = 1;
            chk_en = 1; opchk = 0;
            set_quiet();
        end
    endtask
    // t = cycles since the issue cycle; BUSY spans t=1..fin, DONE is t=fin+1
    task automatic run_op(input logic [31:0] ir, a, b, input int rdy_at, input logic [31:0] res,
                          input logic exc, input int abort_at, input bit by_reset);
        bit mul, tmo, exc_f, post;
        int fin, last;
        mul   = ir[6:2] == 5'b00110;
        tmo   = !(rdy_at > 0 && rdy_at <= TO);
        fin   = tmo ? TO : rdy_at;
        exc_f = tmo || exc;
        last  = abort_at > 0 ? abort_at + 2 : fin + 1;
        for (int t = 0; t <= last; t++) begin
            step();
            post         = abort_at > 0 && t > abort_at;
            IR_X         = post ? 32'd0 : ir;
            A_X          = post ? 32'd0 : a;
            B_X          = post ? 32'd0 : b;
            kill         = !by_reset && abort_at > 0 && t == abort_at;
            reset        = by_reset && t == abort_at;
            md_ready     = t >= 1 && t == rdy_at;
            md_result    = md_ready ? res : 32'hdead_beef;
            md_exception = md_ready ? exc : 1'b1;
            chk_en       = !(by_reset && t == abort_at);
            opchk        = 1;
            e_mult       = t == 0 && mul;
            e_div        = t == 0 && !mul;
            e_stall      = t <= fin && !(abort_at > 0 && t >= abort_at);
            e_valid      = abort_at == 0 && t == fin + 1;
            e_exc        = e_valid && exc_f;
            e_reg        = !e_valid ? 5'd0 : exc_f ? 5'd30 : ir[26:22];
            e_data       = !e_valid ? 32'd0 : exc_f ? (mul ? 32'd4 : 32'd5) : res;
            e_opa        = (by_reset && post) ? 32'd0 : a;
            e_opb        = (by_reset && post) ? 32'd0 : b;
        end
    endtask
    initial begin
        chk_en = 0; opchk = 0; set_quiet(); clr_counts();
        reset = 1; kill = 0; IR_X = 0; A_X = 0; B_X = 0;
        md_ready = 0; md_result = 0; md_exception = 0;
        e_opa = 0; e_opb = 0;
        step();
        chk_en = 1; opchk = 1;
        step();
        idle(2, 32'd0, 1'b0);
        clr_counts();
        run_op(rtype(5'b00110, 5'd5, 5'd2, 5'd3), 32'd7, 32'd6, 4, 32'd42, 1'b0, 0, 1'b0);
        idle(1, 32'd0, 1'b0);
        chk("mul_stall_cycles", n_stall, 5);
        chk("mul_pulses", n_mult, 1);
        chk("mul_valid_pulses", n_valid, 1);
        chk("mul_data", last_data, 42);
        chk("mul_reg", 32'(last_reg), 5);
        clr_counts();
        run_op(rtype(5'b00111, 5'd4, 5'd1, 5'd0), 32'd100, 32'd0, 2, 32'd0, 1'b1, 0, 1'b0);
        idle(1, 32'd0, 1'b0);
        chk("div0_reg", 32'(last_reg), 30);
        chk("div0_data", last_data, 5);
        chk("div0_exc", 32'(last_exc), 1);
        chk("div_pulses", n_div, 1);
        clr_counts();
        run_op(rtype(5'b00110, 5'd7, 5'd2, 5'd3), 32'd9, 32'd9, 0, 32'd0, 1'b0, 0, 1'b0);
        idle(1, 32'd0, 1'b0);
        chk("timeout_stall_cycles", n_stall, 41);
        chk("timeout_reg", 32'(last_reg), 30);
        chk("timeout_data", last_data, 4);
        clr_counts();
        run_op(rtype(5'b00110, 5'd12, 5'd2, 5'd3), 32'd8, 32'd8, 40, 32'd99, 1'b0, 0, 1'b0);
        idle(1, 32'd0, 1'b0);
        chk("ready_at_limit_data", last_data, 99);
        chk("ready_at_limit_stall", n_stall, 41);
        clr_counts();
        run_op(rtype(5'b00110, 5'd8, 5'd2, 5'd3), 32'd3, 32'd5, 3, 32'd15, 1'b0, 0, 1'b0);
        run_op(rtype(5'b00110, 5'd9, 5'd2, 5'd3), 32'd2, 32'd2, 3, 32'd4, 1'b0, 0, 1'b0);
        idle(2, 32'd0, 1'b0);
        chk("b2b_pulses", n_mult, 2);
        chk("b2b_valid_pulses", n_valid, 2);
        chk("b2b_stall_cycles", n_stall, 8);
        clr_counts();
        run_op(rtype(5'b00110, 5'd6, 5'd2, 5'd3), 32'd4, 32'd4, 3, 32'd16, 1'b0, 2, 1'b0);
        idle(2, 32'd0, 1'b0);
        chk("kill_valid_pulses", n_valid, 0);
        chk("kill_stall_cycles", n_stall, 2);
        clr_counts();
        idle(1, rtype(5'b00110, 5'd5, 5'd2, 5'd3), 1'b1);
        idle(1, {5'b00001, 20'd0, 5'b00110, 2'b00}, 1'b0);
        chk("suppressed_pulses", n_mult, 0);
        clr_counts();
        run_op(rtype(5'b00111, 5'd3, 5'd2, 5'd1), 32'd50, 32'd7, 0, 32'd0, 1'b0, 2, 1'b1);
        run_op(rtype(5'b00111, 5'd7, 5'd2, 5'd1), 32'd20, 32'd3, 1, 32'd6, 1'b0, 0, 1'b0);
        idle(2, 32'd0, 1'b0);
        chk("post_reset_div_pulses", n_div, 2);
        chk("post_reset_data", last_data, 6);
        chk("post_reset_reg", 32'(last_reg), 7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
